mem_bist_ctrl: RTL and testbench
================================

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 2, data width of the memory word.
REQ-002 SHALL have parameter DEPTH, default 8, number of memory locations under test.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, address width; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum wait cycles for ready_i per transaction.
REQ-005 SHALL have clk_i, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have rst_i, input, 1, asynchronous active-low reset (0 = in reset).
REQ-007 SHALL have start_i, input, 1, request to begin a write-then-read-back test.
REQ-008 SHALL have pattern_i, input, WIDTH, seed XORed into every data word; captured at start.
REQ-009 SHALL have valid_o, output, 1, transaction request to memory.
REQ-010 SHALL have wr_rd_o, output, 1, 1 = write, 0 = read.
REQ-011 SHALL have addr_o, output, ADDR_WIDTH, transaction address.
REQ-012 SHALL have wr_data_o, output, WIDTH, write data.
REQ-013 SHALL have rd_data_i, input, WIDTH, read data from memory.
REQ-014 SHALL have ready_i, input, 1, memory completes the current transaction.
REQ-015 SHALL have busy_o, output, 1, test in progress.
REQ-016 SHALL have done_o, output, 1, test finished; held until the next accepted start.
REQ-017 SHALL have pass_o, output, 1, zero mismatches and no timeout; valid only while done_o = 1.
REQ-018 SHALL have err_count_o, output, ADDR_WIDTH+1, number of read mismatches.
REQ-019 SHALL have fail_addr_o, output, ADDR_WIDTH, address of the first mismatch.
REQ-020 SHALL have timeout_o, output, 1, test aborted on ready_i timeout.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, READ, DONE; all outputs registered.
REQ-022 SHALL define expected data for address a as a[WIDTH-1:0] XOR pattern, zero-extending a if ADDR_WIDTH < WIDTH.
REQ-023 SHALL, in IDLE or DONE, on start_i = 1 at a rising edge, capture pattern_i, clear the counters, done_o, pass_o, err_count_o, fail_addr_o and timeout_o, and enter WRITE with addr_o = 0 and valid_o = 1 on the following cycle.
REQ-024 SHALL ignore start_i while in WRITE or READ.
REQ-025 SHALL hold valid_o, wr_rd_o, addr_o and wr_data_o stable until ready_i = 1 is sampled at a rising edge; the transaction completes on that edge.
REQ-026 SHALL, in WRITE, drive wr_rd_o = 1 and wr_data_o = expected(addr_o); on completion at addr DEPTH-1, enter READ with addr_o = 0, otherwise increment addr_o; valid_o stays 1 (back-to-back).
REQ-027 SHALL, in READ, drive wr_rd_o = 0 and wr_data_o = 0, and sample rd_data_i on the completing edge.
REQ-028 SHALL, on a READ mismatch, increment err_count_o, and record addr_o in fail_addr_o only if err_count_o was 0.
REQ-029 SHALL, on READ completion at addr DEPTH-1, enter DONE and drive valid_o = 0, busy_o = 0, done_o = 1, and pass_o = (err_count_o == 0 after the final compare).
REQ-030 SHALL count cycles with valid_o = 1 and ready_i = 0; when the count reaches TIMEOUT, set timeout_o = 1 and enter DONE with pass_o = 0. The count clears on every completion.
REQ-031 SHALL drive busy_o = 1 exactly while in WRITE or READ.
REQ-032 SHALL accept ready_i while valid_o = 0 without any effect.

Reset
REQ-033 SHALL, on rst_i = 0, immediately force the FSM to IDLE and drive all outputs and counters to 0, including mid-transaction.
REQ-034 SHALL leave reset synchronously to clk_i; the first start_i is honoured on the first rising edge at which rst_i = 1.

Verification
REQ-035 Setup for all scenarios: default parameters, zero-wait memory model (ready_i = valid_o), pattern_i = 2'b01.
  - Stimulus: run one test.
  - Required response: writes addr 0..7 with data 1,0,3,2,1,0,3,2; 8 reads follow; done_o = 1, pass_o = 1, err_count_o = 0; 16 transaction cycles plus 1 start cycle.
REQ-036 Stimulus: memory model corrupts the read data at addr 3 and addr 6 (read data XOR 2'b11).
  - Required response: err_count_o = 2, fail_addr_o = 3, pass_o = 0.
REQ-037 Stimulus: memory model inserts 2 wait cycles on every transaction.
  - Required response: each request holds stable for 3 cycles; pass_o = 1; timeout_o = 0.
REQ-038 Stimulus: ready_i is held at 0 from the third write.
  - Required response: after 16 stall cycles, timeout_o = 1, done_o = 1, pass_o = 0, valid_o = 0.
REQ-039 Stimulus: rst_i = 0 during the READ at addr 4.
  - Required response: valid_o = 0 and busy_o = 0 without waiting for a clock edge; after release and start_i, a full test passes.
REQ-040 Stimulus: start_i pulsed during WRITE, then again after DONE with pattern_i = 2'b10.
  - Required response: the first pulse is ignored; the second clears the results and writes 2,3,0,1,2,3,0,1.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes addr^pattern to every location, reads back and compares.
// Latency: 1 cycle from accepted start to first request; one cycle per zero-wait transaction.
// Backpressure: each request is held stable until ready_i; aborts after TIMEOUT stalled cycles.
module mem_bist_ctrl #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      pattern_i,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wr_data_o,
    input  logic [WIDTH-1:0]      rd_data_i,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  timeout_o
);

    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int EXT_W  = (ADDR_WIDTH > WIDTH) ? ADDR_WIDTH : WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      pat_q, pat_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [WIDTH-1:0]      wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH:0]   err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_q, fail_d;
    logic                  tmo_q, tmo_d;
    logic [CNT_W-1:0]      wait_q, wait_d;

    logic                  xfer;
    logic                  stall_expired;
    logic                  mismatch;
    logic [ADDR_WIDTH:0]   err_next;

    // Expected word: address zero-extended (or truncated) to WIDTH, XORed with the seed.
    function automatic logic [WIDTH-1:0] expected(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0]      pat);
        logic [EXT_W-1:0] wide;
        wide = EXT_W'(a);
        return wide[WIDTH-1:0] ^ pat;
    endfunction

    assign xfer          = valid_q & ready_i;
    assign stall_expired = valid_q & ~ready_i & (wait_q == CNT_W'(TIMEOUT - 1));
    assign mismatch      = (rd_data_i != expected(addr_q, pat_q));
    assign err_next      = err_q + {{ADDR_WIDTH{1'b0}}, mismatch};

    // State and all output registers; reset clears everything immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pat_q     <= '0;
            valid_q   <= 1'b0;
            wr_rd_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
            tmo_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            valid_q   <= valid_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
            wait_q    <= wait_d;
        end
    end

    // Next-state and next-output logic; a request only advances on a completing edge.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        valid_d   = valid_q;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        fail_d    = fail_q;
        tmo_d     = tmo_q;
        wait_d    = wait_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = WRITE;
                    pat_d     = pattern_i;
                    addr_d    = '0;
                    valid_d   = 1'b1;
                    wr_rd_d   = 1'b1;
                    wr_data_d = expected('0, pattern_i);
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    fail_d    = '0;
                    tmo_d     = 1'b0;
                    wait_d    = '0;
                end
            end
            WRITE, READ: begin
                if (xfer) begin
                    wait_d = '0;
                    if (state_q == READ) begin
                        err_d = err_next;
                        if (mismatch && err_q == '0) begin
                            fail_d = addr_q;
                        end
                    end
                    if (addr_q == LAST_ADDR) begin
                        addr_d    = '0;
                        wr_rd_d   = 1'b0;
                        wr_data_d = '0;
                        if (state_q == WRITE) begin
                            state_d = READ;
                        end else begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_next == '0);
                        end
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (state_q == WRITE) begin
                            wr_data_d = expected(addr_q + ADDR_WIDTH'(1), pat_q);
                        end
                    end
                end else if (stall_expired) begin
                    state_d   = DONE;
                    valid_d   = 1'b0;
                    wr_rd_d   = 1'b0;
                    wr_data_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    tmo_d     = 1'b1;
                    wait_d    = '0;
                end else if (valid_q) begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid_o     = valid_q;
    assign wr_rd_o     = wr_rd_q;
    assign addr_o      = addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_addr_o = fail_q;
    assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: directed scenarios plus randomized runs against a memory model.
// Expected results come from a transaction-level model of the write/read-back test.
// Memory model supports wait states, stalls, read corruption and forced ready.
module tb_mem_bist_ctrl;
    localparam int W  = 2;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [W-1:0]  pattern_i = '0;
    logic          valid_o, wr_rd_o, busy_o, done_o, pass_o, timeout_o;
    logic [AW-1:0] addr_o, fail_addr_o;
    logic [W-1:0]  wr_data_o, rd_data_i;
    logic          ready_i;
    logic [AW:0]   err_count_o;

    mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pattern_i(pattern_i),
        .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wr_data_o(wr_data_o),
        .rd_data_i(rd_data_i), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_count_o(err_count_o), .fail_addr_o(fail_addr_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model configuration (driven by the stimulus block only)
    int           wait_n = 0;
    int           stall_at = -1;
    bit           force_rdy = 1'b0;
    logic [W-1:0] corrupt [D];

    // Memory model state (owned by the model process only)
    int           wait_ctr = 0;
    int           n_xfer = 0;
    logic [W-1:0] mem [D];

    assign ready_i   = force_rdy | (valid_o && wait_ctr >= wait_n &&
                                    !(stall_at >= 0 && n_xfer >= stall_at));
    assign rd_data_i = mem[addr_o] ^ corrupt[addr_o];

    // Memory: stores writes, counts completed transactions and wait cycles
    always @(posedge clk_i) begin
        if (valid_o && ready_i) begin
            wait_ctr <= 0;
            n_xfer   <= n_xfer + 1;
            if (wr_rd_o) mem[addr_o] <= wr_data_o;
        end else if (valid_o) begin
            wait_ctr <= wait_ctr + 1;
        end else begin
            wait_ctr <= 0;
        end
    end

    int n_asserts = 0;
    int n_fail = 0;

    bit           rec_wr[$];
    logic [AW-1:0] rec_addr[$];
    logic [W-1:0] rec_data[$];
    int           rec_hold[$];
    int           cycles;
    int           stall_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one test and observe it until done_o; optionally re-pulse start mid-test.
    task automatic run(input logic [W-1:0] pat, input int wn, input int stall_rel,
                       input int repulse_at);
        int  hold;
        bit  pulsed;
        hold = 0;
        pulsed = 1'b0;
        rec_wr.delete(); rec_addr.delete(); rec_data.delete(); rec_hold.delete();
        cycles = 0;
        stall_cycles = 0;
        wait_n = wn;
        stall_at = (stall_rel >= 0) ? n_xfer + stall_rel : -1;
        pattern_i = pat;
        start_i = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            cycles++;
            if (c == 0) begin
                pattern_i = ~pat;
                chk("start_busy", 32'(busy_o), 32'd1);
                chk("start_clears", {28'd0, done_o, pass_o, timeout_o, 1'b0} | 32'(err_count_o) | 32'(fail_addr_o), 32'd0);
            end
            if (done_o) break;
            if (valid_o) begin
                hold++;
                if (!ready_i) stall_cycles++;
                else begin
                    rec_wr.push_back(wr_rd_o);
                    rec_addr.push_back(addr_o);
                    rec_data.push_back(wr_data_o);
                    rec_hold.push_back(hold);
                    hold = 0;
                end
            end
            if (start_i) start_i = 1'b0;
            else if (repulse_at >= 0 && !pulsed && rec_wr.size() == repulse_at) begin
                start_i = 1'b1;
                pulsed = 1'b1;
            end
        end
        start_i = 1'b0;
        chk("done_reached", 32'(done_o), 32'd1);
    endtask

    // Compare a completed run with the transaction-level model of the test
    task automatic verify(input logic [W-1:0] pat, input int wn);
        int  exp_err;
        int  exp_fail;
        int  bad_seq;
        int  bad_hold;
        exp_err = 0;
        exp_fail = 0;
        for (int a = D - 1; a >= 0; a--) begin
            if (corrupt[a] != '0) begin
                exp_err++;
                exp_fail = a;
            end
        end
        bad_seq = 0;
        bad_hold = 0;
        chk("txn_count", 32'(rec_wr.size()), 32'(2 * D));
        for (int i = 0; i < 2 * D && i < rec_wr.size(); i++) begin
            int a;
            logic [W-1:0] ed;
            a = i % D;
            ed = (i < D) ? (W'(a) ^ pat) : '0;
            if (rec_wr[i] !== (i < D) || rec_addr[i] !== AW'(a) || rec_data[i] !== ed) bad_seq++;
            if (rec_hold[i] != wn + 1) bad_hold++;
        end
        chk("txn_sequence_errors", 32'(bad_seq), 32'd0);
        chk("hold_errors", 32'(bad_hold), 32'd0);
        chk("pass", 32'(pass_o), 32'(exp_err == 0));
        chk("err_count", 32'(err_count_o), 32'(exp_err));
        if (exp_err > 0) chk("fail_addr", 32'(fail_addr_o), 32'(exp_fail));
        chk("timeout_clear", 32'(timeout_o), 32'd0);
        chk("idle_outputs", {30'd0, busy_o, valid_o}, 32'd0);
        chk("cycles", 32'(cycles), 32'(1 + 2 * D * (wn + 1)));
    endtask

    task automatic clear_corrupt();
        for (int a = 0; a < D; a++) corrupt[a] = '0;
    endtask

    initial begin
        int exp01 [8];
        int exp10 [8];
        int bad;
        exp01 = '{1, 0, 3, 2, 1, 0, 3, 2};
        exp10 = '{2, 3, 0, 1, 2, 3, 0, 1};
        clear_corrupt();

        // Asynchronous reset before any clock edge
        #2 rst_i = 1'b0;
        #1;
        chk("reset_outputs", {26'd0, valid_o, wr_rd_o, busy_o, done_o, pass_o, timeout_o}, 32'd0);
        chk("reset_counters", 32'(err_count_o) | 32'(fail_addr_o) | 32'(addr_o) | 32'(wr_data_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Zero-wait, pattern 01
        run(2'b01, 0, -1, -1);
        verify(2'b01, 0);
        bad = 0;
        for (int i = 0; i < D && i < rec_data.size(); i++) if (int'(rec_data[i]) != exp01[i]) bad++;
        chk("write_data_01", 32'(bad), 32'd0);

        // ready_i while idle in DONE has no effect
        force_rdy = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("force_ready_hold", {29'd0, done_o, pass_o, valid_o}, 32'b110);
        force_rdy = 1'b0;

        // Read corruption at addr 3 and 6
        corrupt[3] = 2'b11;
        corrupt[6] = 2'b11;
        run(2'b01, 0, -1, -1);
        verify(2'b01, 0);
        chk("corrupt_err2", 32'(err_count_o), 32'd2);
        chk("corrupt_fail3", 32'(fail_addr_o), 32'd3);
        clear_corrupt();

        // Start pulse during WRITE ignored, then restart with pattern 10
        run(2'b01, 0, -1, 3);
        verify(2'b01, 0);
        run(2'b10, 0, -1, -1);
        verify(2'b10, 0);
        bad = 0;
        for (int i = 0; i < D && i < rec_data.size(); i++) if (int'(rec_data[i]) != exp10[i]) bad++;
        chk("write_data_10", 32'(bad), 32'd0);

        // Two wait cycles per transaction
        run(2'b01, 2, -1, -1);
        verify(2'b01, 2);

        // Stall from the third write onwards
        run(2'b01, 0, 2, -1);
        chk("tmo_timeout", 32'(timeout_o), 32'd1);
        chk("tmo_flags", {29'd0, done_o, pass_o, valid_o}, 32'b100);
        chk("tmo_stall_cycles", 32'(stall_cycles), 32'(TO));
        chk("tmo_writes_done", 32'(rec_wr.size()), 32'd2);
        stall_at = -1;

        // Reset during READ at addr 4, then a clean run
        pattern_i = 2'b01;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 200 && !(valid_o && !wr_rd_o && addr_o == 3'd4); c++) @(negedge clk_i);
        chk("reached_read4", {29'd0, valid_o, wr_rd_o, 1'b0} | 32'(addr_o), 32'b100 | 32'd4);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_valid_busy", {30'd0, valid_o, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        run(2'b01, 0, -1, -1);
        verify(2'b01, 0);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            logic [W-1:0] pat;
            int wn;
            pat = W'($urandom);
            wn = $urandom_range(0, 3);
            for (int a = 0; a < D; a++)
                corrupt[a] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 3)) : '0;
            run(pat, wn, -1, -1);
            verify(pat, wn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
